// File: rtl/bram_pixel_reader.sv
// bram_pixel_reader: streams NUM_PIXELS consecutive words out of a BRAM that
// has a one-cycle registered read port. Pixels leave on a valid/ready
// interface. A 4-entry FIFO absorbs the read latency, and read issue is
// throttled so that data already requested always has a free slot.
module bram_pixel_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PIXELS = 784,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic [ADDR_WIDTH-1:0] pix_index,
  output logic                  pix_last
);

  // The issue counter must be able to hold NUM_PIXELS == 2**ADDR_WIDTH.
  localparam int                    CNT_W    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CNT_W-1:0]      TOTAL    = CNT_W'(NUM_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_e;

  state_e                r_state;
  state_e                w_state_next;

  // Read pipeline: r_rd_issue marks the cycle in which bram_addr is a valid
  // request. r_rd_d1 marks the following cycle, when bram_data holds the word.
  logic                  r_rd_issue;
  logic                  r_rd_d1;
  logic [CNT_W-1:0]      r_issue_cnt;
  logic [ADDR_WIDTH-1:0] r_bram_addr;

  logic [DATA_WIDTH-1:0] r_fifo_mem [4];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [2:0]            r_fifo_count;
  logic [ADDR_WIDTH-1:0] r_pix_index;
  logic                  r_done;

  logic                  w_busy;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_pop_last;
  logic                  w_done_set;
  logic                  w_clear;
  logic                  w_issue;
  logic [3:0]            w_committed;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values; blocking here creates order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Handshake, flow-control and next-state decode.
  // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_pop      = pix_valid & pix_ready;
    w_push     = r_rd_d1;
    w_start    = (r_state == S_IDLE) & start & ~abort;
    w_abort    = w_busy & abort;
    w_pop_last = w_pop & (r_pix_index == LAST_IDX);
    w_done_set = w_busy & ~abort & w_pop_last;
    w_clear    = w_abort | w_done_set;
    // Slots already promised: stored words, both in-flight reads, minus the
    // word leaving this cycle. A new read may be issued only if a slot is left.
    w_committed = {1'b0, r_fifo_count} + {3'b000, r_rd_issue}
                + {3'b000, r_rd_d1} - {3'b000, w_pop};
    w_issue = w_start
            | ((r_state == S_FETCH) & ~abort & (r_issue_cnt != TOTAL)
               & (w_committed < 4'd4));

    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (abort || w_done_set)
          w_state_next = S_IDLE;
        else if ((r_issue_cnt + CNT_W'(w_issue)) == TOTAL)
          w_state_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (abort || w_done_set) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Read issue pipeline, address generation, FIFO pointers and stream index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_issue   <= 1'b0;
      r_rd_d1      <= 1'b0;
      r_issue_cnt  <= '0;
      r_bram_addr  <= BASE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      r_pix_index  <= '0;
    end else if (w_clear) begin
      // End of frame or abort: drop stored words and any in-flight reads.
      r_rd_issue   <= 1'b0;
      r_rd_d1      <= 1'b0;
      r_issue_cnt  <= '0;
      r_bram_addr  <= BASE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      r_pix_index  <= '0;
    end else begin
      r_rd_issue <= w_issue;
      r_rd_d1    <= r_rd_issue;
      if (w_start) begin
        r_issue_cnt <= CNT_W'(1);
        r_bram_addr <= BASE;
      end else if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
        r_bram_addr <= r_bram_addr + 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_pix_index <= r_pix_index + 1'b1;
      end
      r_fifo_count <= r_fifo_count + 3'(w_push) - 3'(w_pop);
    end
  end

  // FIFO storage; contents are qualified by r_fifo_count, never read when empty.
  // NOTE: the storage array is deliberately not reset; pointers and count define its contents, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= bram_data;
  end

  // One-cycle done pulse following the last handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= w_done_set;
  end

  assign busy      = w_busy;
  assign done      = r_done;
  assign bram_addr = r_bram_addr;
  assign pix_valid = (r_fifo_count != 3'd0);
  assign pix_data  = pix_valid ? r_fifo_mem[r_rd_ptr] : '0;
  assign pix_index = r_pix_index;
  assign pix_last  = pix_valid & (r_pix_index == LAST_IDX);

endmodule

// File: tb/tb_bram_pixel_reader.sv
// Directed bench for bram_pixel_reader. Three instances share one clock:
// an 8-pixel frame at address 0, a 1-pixel frame at address 5, and an
// 8-pixel frame ending at the top of the address space. Each instance has
// its own BRAM model with mem[k] = (3k) % 256.
module tb_bram_pixel_reader;
  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Main instance: NUM_PIXELS=8, BASE_ADDR=0.
  logic          m_start = 1'b0, m_abort = 1'b0, m_ready = 1'b0;
  logic          m_busy, m_done, m_valid, m_last;
  logic [AW-1:0] m_addr, m_index;
  logic [DW-1:0] m_bdata, m_pdata;

  // Single-pixel instance: NUM_PIXELS=1, BASE_ADDR=5.
  logic          o_start = 1'b0, o_abort = 1'b0, o_ready = 1'b1;
  logic          o_busy, o_done, o_valid, o_last;
  logic [AW-1:0] o_addr, o_index;
  logic [DW-1:0] o_bdata, o_pdata;

  // Top-of-address-space instance: NUM_PIXELS=8, BASE_ADDR=16'hFFF8.
  logic          w_start = 1'b0, w_abort = 1'b0, w_ready = 1'b1;
  logic          w_busy, w_done, w_valid, w_last;
  logic [AW-1:0] w_addr, w_index;
  logic [DW-1:0] w_bdata, w_pdata;

  bram_pixel_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PIXELS(8), .BASE_ADDR(0)) u_main (
    .clk(clk), .rst_n(rst_n), .start(m_start), .abort(m_abort), .busy(m_busy), .done(m_done),
    .bram_addr(m_addr), .bram_data(m_bdata), .pix_valid(m_valid), .pix_ready(m_ready),
    .pix_data(m_pdata), .pix_index(m_index), .pix_last(m_last));

  bram_pixel_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PIXELS(1), .BASE_ADDR(5)) u_one (
    .clk(clk), .rst_n(rst_n), .start(o_start), .abort(o_abort), .busy(o_busy), .done(o_done),
    .bram_addr(o_addr), .bram_data(o_bdata), .pix_valid(o_valid), .pix_ready(o_ready),
    .pix_data(o_pdata), .pix_index(o_index), .pix_last(o_last));

  bram_pixel_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PIXELS(8), .BASE_ADDR(16'hFFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start), .abort(w_abort), .busy(w_busy), .done(w_done),
    .bram_addr(w_addr), .bram_data(w_bdata), .pix_valid(w_valid), .pix_ready(w_ready),
    .pix_data(w_pdata), .pix_index(w_index), .pix_last(w_last));

  function automatic logic [7:0] mem_val(input logic [31:0] a);
    logic [31:0] p;
    p = a * 32'd3;
    return p[7:0];
  endfunction

  // BRAM models: registered read, data valid one cycle after the address.
  always @(posedge clk) begin
    m_bdata <= mem_val(32'(m_addr));
    o_bdata <= mem_val(32'(o_addr));
    w_bdata <= mem_val(32'(w_addr));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full 8-pixel frame on the main instance with pix_ready held high.
  // start is also pulsed in cycle 5 and on the last-handshake cycle (10),
  // both while busy, and must have no effect.
  task automatic run_frame(input string tag);
    m_ready = 1'b1;
    m_start = 1'b1;
    step();
    for (int cyc = 1; cyc <= 12; cyc++) begin
      m_start = (cyc == 5 || cyc == 10);
      if (cyc <= 2) begin
        chk({tag, "_busy_early"}, 32'(m_busy), 1);
        chk({tag, "_valid_early"}, 32'(m_valid), 0);
      end
      if (cyc <= 8) chk({tag, "_addr"}, 32'(m_addr), cyc - 1);
      if (cyc >= 3 && cyc <= 10) begin
        chk({tag, "_valid"}, 32'(m_valid), 1);
        chk({tag, "_index"}, 32'(m_index), cyc - 3);
        chk({tag, "_data"}, 32'(m_pdata), 32'(mem_val(32'(cyc - 3))));
        chk({tag, "_last"}, 32'(m_last), (cyc == 10) ? 1 : 0);
        chk({tag, "_done_low"}, 32'(m_done), 0);
      end
      if (cyc == 11) begin
        chk({tag, "_done_pulse"}, 32'(m_done), 1);
        chk({tag, "_busy_drop"}, 32'(m_busy), 0);
        chk({tag, "_valid_end"}, 32'(m_valid), 0);
      end
      if (cyc == 12) begin
        chk({tag, "_done_once"}, 32'(m_done), 0);
        chk({tag, "_idle_busy"}, 32'(m_busy), 0);
        chk({tag, "_idle_addr"}, 32'(m_addr), 0);
        chk({tag, "_idle_index"}, 32'(m_index), 0);
      end
      step();
    end
    m_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int ndone;

    // Reset state.
    step();
    step();
    chk("rst_busy", 32'(m_busy), 0);
    chk("rst_done", 32'(m_done), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_data", 32'(m_pdata), 0);
    chk("rst_index", 32'(m_index), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_addr_one", 32'(o_addr), 5);
    chk("rst_addr_wrap", 32'(w_addr), 32'h0000FFF8);
    rst_n = 1'b1;
    step();

    // Basic frame at 1 pixel/cycle, start pulses while busy ignored.
    run_frame("t2");
    step();
    // Start in IDLE after done restarts at index 0.
    run_frame("t4");

    // Reset mid-frame while pixel 5 is presented.
    m_ready = 1'b1;
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    repeat (7) step();
    chk("t1_pre_index", 32'(m_index), 5);
    rst_n = 1'b0;
    #1;
    chk("t1_busy", 32'(m_busy), 0);
    chk("t1_done", 32'(m_done), 0);
    chk("t1_valid", 32'(m_valid), 0);
    chk("t1_last", 32'(m_last), 0);
    chk("t1_data", 32'(m_pdata), 0);
    chk("t1_index", 32'(m_index), 0);
    chk("t1_addr", 32'(m_addr), 0);
    step();
    rst_n = 1'b1;
    step();
    run_frame("t1");
    step();

    // Backpressure: ready only in cycle 3, low in cycles 4..13, then random.
    m_ready = 1'b1;
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    step();
    step();
    chk("t3_c3_valid", 32'(m_valid), 1);
    chk("t3_c3_data", 32'(m_pdata), 0);
    step();
    m_ready = 1'b0;
    for (int cyc = 4; cyc <= 13; cyc++) begin
      chk("t3_stall_valid", 32'(m_valid), 1);
      chk("t3_stall_index", 32'(m_index), 1);
      chk("t3_stall_data", 32'(m_pdata), 3);
      if (cyc >= 5) chk("t3_stall_addr", 32'(m_addr), 4);
      step();
    end
    idx = 1;
    ndone = 0;
    for (int t = 0; t < 200; t++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (m_busy) chk("t3_addr_bound", 32'(32'(m_addr) <= idx + 3), 1);
      if (m_valid) begin
        chk("t3_index", 32'(m_index), idx);
        chk("t3_data", 32'(m_pdata), 32'(mem_val(32'(idx))));
        chk("t3_last", 32'(m_last), (idx == 7) ? 1 : 0);
        if (m_ready) idx++;
      end
      if (m_done) ndone++;
      step();
    end
    chk("t3_count", idx, 8);
    chk("t3_done_count", ndone, 1);
    chk("t3_idle", 32'(m_busy), 0);

    // Abort after the pixel-3 handshake.
    m_ready = 1'b1;
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    step();
    step();
    for (int cyc = 3; cyc <= 6; cyc++) begin
      chk("t5_pre_index", 32'(m_index), cyc - 3);
      step();
    end
    m_ready = 1'b0;
    m_abort = 1'b1;
    step();
    m_abort = 1'b0;
    chk("t5_valid", 32'(m_valid), 0);
    chk("t5_busy", 32'(m_busy), 0);
    chk("t5_done", 32'(m_done), 0);
    chk("t5_index", 32'(m_index), 0);
    chk("t5_addr", 32'(m_addr), 0);
    ndone = 0;
    for (int t = 0; t < 10; t++) begin
      if (m_done || m_valid) ndone++;
      step();
    end
    chk("t5_quiet", ndone, 0);
    run_frame("t5");

    // Single-pixel frame.
    o_start = 1'b1;
    step();
    o_start = 1'b0;
    chk("t6a_busy", 32'(o_busy), 1);
    chk("t6a_addr", 32'(o_addr), 5);
    step();
    step();
    chk("t6a_valid", 32'(o_valid), 1);
    chk("t6a_last", 32'(o_last), 1);
    chk("t6a_index", 32'(o_index), 0);
    chk("t6a_data", 32'(o_pdata), 15);
    step();
    chk("t6a_done", 32'(o_done), 1);
    chk("t6a_busy_drop", 32'(o_busy), 0);
    chk("t6a_valid_end", 32'(o_valid), 0);
    step();
    chk("t6a_done_once", 32'(o_done), 0);

    // Frame ending at the top of the address space.
    w_start = 1'b1;
    step();
    w_start = 1'b0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      if (cyc <= 8) chk("t6b_addr", 32'(w_addr), 32'h0000FFF8 + cyc - 1);
      if (cyc == 9 || cyc == 10) chk("t6b_addr_hold", 32'(w_addr), 32'h0000FFFF);
      if (cyc >= 3 && cyc <= 10) begin
        chk("t6b_valid", 32'(w_valid), 1);
        chk("t6b_index", 32'(w_index), cyc - 3);
        chk("t6b_data", 32'(w_pdata), 32'(mem_val(32'h0000FFF8 + cyc - 3)));
        chk("t6b_last", 32'(w_last), (cyc == 10) ? 1 : 0);
      end
      if (cyc == 11) begin
        chk("t6b_done", 32'(w_done), 1);
        chk("t6b_addr_ret", 32'(w_addr), 32'h0000FFF8);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
